// File: rtl/audio_io_pkg.sv
// Register map and bit positions shared by the audio I/O Avalon-MM ports.
package audio_io_pkg;
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_CONTROL  = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  localparam int MASK_NE  = 0;
  localparam int MASK_OVF = 1;
endpackage

// File: rtl/audio_in_fifo.sv
// Register-array sample FIFO; flush wins, push when full only lands if a pop frees a slot.
module audio_in_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (PW+1)'(DEPTH));
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !flush && (!full || pop);
    do_pop   = pop && !flush && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/nios_audio_in_capture.sv
// Avalon-MM audio capture port: strobed samples into a FIFO drained through DATA.
// Define AUDIO_IN_IRQ_EN to add the irq output and the IRQ_MASK register.
module nios_audio_in_capture
  import audio_io_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  input  logic             in_strobe
`ifdef AUDIO_IN_IRQ_EN
  ,output logic            irq
`endif
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             rd, wr, push, pop, flush;
  logic [WIDTH-1:0] head;
  logic [LW-1:0]    level;
  logic             empty, full;
  logic             enable_q, enable_d, overflow_q, overflow_d;
  logic [31:0]      rdata;

  assign rd    = chipselect && !read_n;
  assign wr    = chipselect && !write_n;
  assign flush = wr && (address == ADDR_CONTROL) && writedata[CTRL_FLUSH];
  assign push  = in_strobe && enable_q && !flush;
  assign pop   = rd && (address == ADDR_DATA) && !empty;

  audio_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .din(in_port), .head(head), .level(level), .empty(empty), .full(full)
  );

  always_comb begin
    enable_d   = enable_q;
    overflow_d = overflow_q;
    if (wr && (address == ADDR_CONTROL)) enable_d = writedata[CTRL_EN];
    if (wr && (address == ADDR_STATUS) && writedata[ST_OVF]) overflow_d = 1'b0;
    // A new drop in the same cycle as a clear keeps the flag set.
    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef AUDIO_IN_IRQ_EN
  logic [1:0] mask_q, mask_d;
  logic       irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (wr && (address == ADDR_IRQ_MASK)) mask_d = writedata[1:0];
    irq_d = (mask_q[MASK_NE] && !empty) || (mask_q[MASK_OVF] && overflow_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata[31:3]};

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_DATA:   if (!empty) rdata = 32'(head);
      ADDR_STATUS: begin
        rdata[ST_EMPTY]                 = empty;
        rdata[ST_FULL]                  = full;
        rdata[ST_OVF]                   = overflow_q;
        rdata[ST_LEVEL_LSB +: 8]        = 8'(level);
      end
`ifdef AUDIO_IN_IRQ_EN
      ADDR_IRQ_MASK: rdata[1:0] = mask_q;
`endif
      ADDR_CONTROL: rdata[CTRL_EN] = enable_q;
      default: rdata = '0;
    endcase
  end

  assign readdata = reset ? 32'h0 : rdata;
endmodule
